// File: rtl/seven_segment_scan_ctrl.sv
// Time-multiplexed scan controller for a common-segment seven-segment display.
// One digit is driven at a time from a display register. A short dark gap
// separates digits to suppress ghosting. New digit data waits in a pending
// register and moves into the display register only at a frame boundary,
// so a frame never shows a mix of old and new digits.
module seven_segment_scan_ctrl #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_GAP     = 2,
    parameter bit ACTIVE_LOW_AN = 1'b1,
    localparam int IW           = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_done
);

    localparam int CNT_MAX  = (REFRESH_DIV > BLANK_GAP) ? REFRESH_DIV : BLANK_GAP;
    localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int GAP_LAST = (BLANK_GAP > 0) ? BLANK_GAP - 1 : 0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = ACTIVE_LOW_AN ? '1 : '0;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} scanState_t;

    scanState_t              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] dispDigits_q, dispDigits_d;
    logic [NUM_DIGITS-1:0]   dispDp_q, dispDp_d;
    logic                    dispLz_q, dispLz_d;
    logic [4*NUM_DIGITS-1:0] pendDigits_q;
    logic [NUM_DIGITS-1:0]   pendDp_q;
    logic                    pendLz_q;
    logic                    pendValid_q, pendValid_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frameDone_q;
    logic                    wrap, xfer;
    logic [IW-1:0]           nextIdx;
    logic                    lastDigit;

    // BCD to {g,f,e,d,c,b,a}; codes 10-15 leave the digit dark.
    function automatic logic [6:0] decodeBcd(input logic [3:0] v);
        case (v)
            4'd0:    decodeBcd = 7'b0111111;
            4'd1:    decodeBcd = 7'b0000110;
            4'd2:    decodeBcd = 7'b1011011;
            4'd3:    decodeBcd = 7'b1001111;
            4'd4:    decodeBcd = 7'b1100110;
            4'd5:    decodeBcd = 7'b1101101;
            4'd6:    decodeBcd = 7'b1111101;
            4'd7:    decodeBcd = 7'b0000111;
            4'd8:    decodeBcd = 7'b1111111;
            4'd9:    decodeBcd = 7'b1101111;
            default: decodeBcd = 7'b0000000;
        endcase
    endfunction

    // A digit is a leading zero when it and every more significant digit are zero.
    function automatic logic isLeadingZero(input logic [4*NUM_DIGITS-1:0] d,
                                           input logic [IW-1:0] k);
        logic anyNonZero;
        anyNonZero = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IW'(j) >= k && d[4*j +: 4] != 4'd0) begin
                anyNonZero = 1'b1;
            end
        end
        isLeadingZero = (k != '0) && !anyNonZero;
    endfunction

    assign lastDigit = (idx_q == IW'(NUM_DIGITS - 1));
    assign nextIdx   = lastDigit ? '0 : idx_q + IW'(1);

    // Scan sequencing: drive period, optional dark gap, advance digit, detect wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wrap    = 1'b0;
        xfer    = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    xfer    = 1'b1;
                end
                DRIVE: begin
                    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                        cnt_d = '0;
                        if (BLANK_GAP == 0) begin
                            idx_d = nextIdx;
                            wrap  = lastDigit;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == CW'(GAP_LAST)) begin
                        cnt_d   = '0;
                        state_d = DRIVE;
                        idx_d   = nextIdx;
                        wrap    = lastDigit;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
            if (wrap) begin
                xfer = 1'b1;
            end
        end
    end

    // Pending data moves to the display only at a frame start; a same-edge load stays pending.
    always_comb begin
        dispDigits_d = dispDigits_q;
        dispDp_d     = dispDp_q;
        dispLz_d     = dispLz_q;
        pendValid_d  = pendValid_q;
        if (xfer && pendValid_q) begin
            dispDigits_d = pendDigits_q;
            dispDp_d     = pendDp_q;
            dispLz_d     = pendLz_q;
            pendValid_d  = 1'b0;
        end
        if (load) begin
            pendValid_d = 1'b1;
        end
    end

    // Output values for the upcoming cycle, derived from the next scan position and display data.
    always_comb begin
        logic [NUM_DIGITS-1:0] oneHot;
        logic [3:0]            nib;
        oneHot = '0;
        oneHot[idx_d] = 1'b1;
        nib  = dispDigits_d[{idx_d, 2'b00} +: 4];
        an_d  = AN_OFF;
        seg_d = 7'b0;
        dp_d  = 1'b0;
        if (state_d == DRIVE) begin
            an_d  = ACTIVE_LOW_AN ? ~oneHot : oneHot;
            seg_d = (dispLz_d && isLeadingZero(dispDigits_d, idx_d)) ? 7'b0 : decodeBcd(nib);
            dp_d  = dispDp_d[idx_d];
        end
    end

    // All state, data and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            dispDigits_q <= '0;
            dispDp_q     <= '0;
            dispLz_q     <= 1'b0;
            pendDigits_q <= '0;
            pendDp_q     <= '0;
            pendLz_q     <= 1'b0;
            pendValid_q  <= 1'b0;
            seg_q        <= 7'b0;
            dp_q         <= 1'b0;
            an_q         <= AN_OFF;
            frameDone_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            dispDigits_q <= dispDigits_d;
            dispDp_q     <= dispDp_d;
            dispLz_q     <= dispLz_d;
            pendValid_q  <= pendValid_d;
            if (load) begin
                pendDigits_q <= digits_in;
                pendDp_q     <= dp_in;
                pendLz_q     <= blank_lz;
            end
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frameDone_q  <= wrap;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frameDone_q;

endmodule
